// File: rtl/normalization_pkg.sv
// normalization_pkg: widths shared by the normalization datapath and its leading-one detector.
package normalization_pkg;
    localparam int SUM_W  = 20;
    localparam int EXP_W  = 6;
    localparam int MAN_W  = 11;
    localparam int EXPF_W = 7;
    localparam int IDX_W  = 5;
    localparam logic [MAN_W-1:0] MAN_LEAD = 11'h400;
endpackage

// File: rtl/normalization_lead_one_detect.sv
// lead_one_detect: index of the most significant set bit of a SUM_W-bit vector, plus an all-zero flag.
module lead_one_detect
    import normalization_pkg::*;
(
    input  logic [SUM_W-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_zero
);
    always_comb begin
        o_idx = '0;
        for (int i = 1; i < SUM_W; i++)
            if (i_vec[i]) o_idx = IDX_W'(i);
    end
    assign o_zero = ~|i_vec;
endmodule

// File: rtl/normalization.sv
// normalization: converts a signed accumulated sum into sign / 11-bit normalized mantissa / exponent, 1-cycle latency.
// Define NORM_ROUND_EN to round to nearest-even instead of truncating the dropped bits.
module normalization
    import normalization_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [SUM_W-1:0]  signed_sum,
    input  logic [EXP_W-1:0]  exp_max,
    output logic              out_valid,
    output logic              sign,
    output logic [MAN_W-1:0]  norm_sum,
    output logic [EXPF_W-1:0] exp_final
);
    logic [SUM_W-1:0]  w_mag;
    logic [IDX_W-1:0]  w_p;
    logic [IDX_W-1:0]  w_shamt;
    logic              w_zero;
    logic [EXPF_W-1:0] w_exp_base;
    logic [MAN_W-1:0]  w_norm;
    logic [EXPF_W-1:0] w_exp;
    logic              r_valid;
    logic              r_sign;
    logic [MAN_W-1:0]  r_norm;
    logic [EXPF_W-1:0] r_exp;
    // -2^19 negates to itself, which read unsigned is exactly the required magnitude
    assign w_mag = signed_sum[SUM_W-1] ? -signed_sum : signed_sum;
    lead_one_detect u_lod (
        .i_vec  (w_mag),
        .o_idx  (w_p),
        .o_zero (w_zero)
    );
    assign w_shamt    = IDX_W'(SUM_W-1) - w_p;
    assign w_exp_base = w_zero ? '0 : EXPF_W'(exp_max) + EXPF_W'(w_p);
`ifdef NORM_ROUND_EN
    logic [SUM_W-1:0] w_aligned;
    logic             w_up;
    logic [MAN_W:0]   w_rnd;
    assign w_aligned = w_mag << w_shamt;
    assign w_up      = w_aligned[SUM_W-MAN_W-1] &
                       (w_aligned[SUM_W-MAN_W] | (|w_aligned[SUM_W-MAN_W-2:0]));
    assign w_rnd     = {1'b0, w_aligned[SUM_W-1 -: MAN_W]} + (MAN_W+1)'(w_up);
    assign w_norm    = w_rnd[MAN_W] ? MAN_LEAD : w_rnd[MAN_W-1:0];
    assign w_exp     = w_exp_base + EXPF_W'(w_rnd[MAN_W]);
`else
    assign w_norm = MAN_W'((w_mag << w_shamt) >> (SUM_W-MAN_W));
    assign w_exp  = w_exp_base;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_sign  <= 1'b0;
            r_norm  <= '0;
            r_exp   <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sign <= signed_sum[SUM_W-1];
                r_norm <= w_norm;
                r_exp  <= w_exp;
            end
        end
    end
    assign out_valid = r_valid;
    assign sign      = r_sign;
    assign norm_sum  = r_norm;
    assign exp_final = r_exp;
endmodule

// File: tb/tb_normalization.sv
// tb_normalization: directed corner cases plus randomized stimulus against an arithmetic reference model.
module tb_normalization;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [19:0] signed_sum;
    logic [5:0]  exp_max;
    logic        out_valid;
    logic        sign;
    logic [10:0] norm_sum;
    logic [6:0]  exp_final;
    int n_tests = 0;
    int n_fail  = 0;
    logic        m_sg;
    logic [10:0] m_n;
    logic [6:0]  m_ex;
    logic        h_sg;
    logic [10:0] h_n;
    logic [6:0]  h_ex;

    normalization dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .signed_sum (signed_sum),
        .exp_max    (exp_max),
        .out_valid  (out_valid),
        .sign       (sign),
        .norm_sum   (norm_sum),
        .exp_final  (exp_final)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic sg,
                             input logic [10:0] n, input logic [6:0] ex);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".sign"},  32'(sign),      32'(sg));
        check({tag, ".norm"},  32'(norm_sum),  32'(n));
        check({tag, ".exp"},   32'(exp_final), 32'(ex));
    endtask

    task automatic step(input logic v, input logic [19:0] s, input logic [5:0] e);
        @(negedge clk);
        in_valid   = v;
        signed_sum = s;
        exp_max    = e;
        @(posedge clk);
        #1;
    endtask

    // Reference: magnitude, floor(log2), scale to [1024,2048), optional RNE on the remainder.
    function automatic void model(input logic [19:0] s, input logic [5:0] e,
                                  output logic sg, output logic [10:0] n, output logic [6:0] ex);
        int si, mag, p, nn, xx, rem, half;
        si  = $signed(s);
        mag = si < 0 ? -si : si;
        sg  = si < 0;
        if (mag == 0) begin
            n = 0; ex = 0;
            return;
        end
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        nn = p >= 10 ? mag >> (p - 10) : mag << (10 - p);
        xx = e + p;
`ifdef NORM_ROUND_EN
        if (p > 10) begin
            rem  = mag % (1 << (p - 10));
            half = 1 << (p - 11);
            if (rem > half || (rem == half && nn % 2 == 1)) nn++;
            if (nn == 2048) begin
                nn = 1024;
                xx++;
            end
        end
`else
        rem = 0; half = 0;
`endif
        n  = 11'(nn);
        ex = 7'(xx);
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; signed_sum = 20'h55555; exp_max = 6'd15;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_out("post_reset_discard", 0, 0, 0, 0);

        step(1, 20'h55555, 6'd15); check_out("alt55555", 1, 0, 11'h555, 7'd33);
        step(1, 20'hFFFFF, 6'd14); check_out("minus1",   1, 1, 11'h400, 7'd14);
        step(1, 20'h80000, 6'd63); check_out("most_neg", 1, 1, 11'h400, 7'd82);
        step(1, 20'h7FFFF, 6'd0);
`ifdef NORM_ROUND_EN
        check_out("max_pos", 1, 0, 11'h400, 7'd19);
`else
        check_out("max_pos", 1, 0, 11'h7FF, 7'd18);
`endif
        step(1, 20'h00000, 6'd40); check_out("zero", 1, 0, 11'h000, 7'd0);
        step(0, 20'h12345, 6'd9);  check_out("hold", 0, 0, 11'h000, 7'd0);

        h_sg = 0; h_n = 0; h_ex = 0;
        for (int i = 0; i < 400; i++) begin
            logic [19:0] s;
            logic [5:0]  e;
            logic        v;
            s = 20'($urandom) >> $urandom_range(0, 19);
            if ($urandom_range(0, 1) == 1) s = -s;
            if ($urandom_range(0, 31) == 0) s = $urandom_range(0, 1) == 1 ? 20'h80000 : 20'h0;
            e = 6'($urandom);
            v = $urandom_range(0, 3) != 0;
            step(v, s, e);
            if (v) begin
                model(s, e, m_sg, m_n, m_ex);
                h_sg = m_sg; h_n = m_n; h_ex = m_ex;
            end
            check_out($sformatf("rand%0d", i), v, h_sg, h_n, h_ex);
        end

        step(1, 20'h55555, 6'd15); check_out("pre_rst", 1, 0, 11'h555, 7'd33);
        @(negedge clk);
        in_valid = 1'b1; signed_sum = 20'h7FFFF; exp_max = 6'd5;
        #2 rst_n = 1'b0;
        #1 check_out("async_rst", 0, 0, 0, 0);
        @(posedge clk);
        #1 check_out("rst_hold", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        step(1, 20'hFFFFF, 6'd14); check_out("after_rst", 1, 1, 11'h400, 7'd14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
